// File: rtl/score_pkg.sv
// rtl/score_pkg.sv - shared types and constants for the Pong score controller
package score_pkg;

  // Scoring is live in PLAY; OVER freezes everything until new_game.
  typedef enum logic {
    PLAY = 1'b0,
    OVER = 1'b1
  } state_e;

  localparam int SCORE_W = 4;

  // Player index, also the encoding of the winner output.
  localparam logic P1 = 1'b0;
  localparam logic P2 = 1'b1;

endpackage

// File: rtl/score_ctrl_beep_timer.sv
// rtl/score_ctrl_beep_timer.sv - beep length counter, optional win melody (SCORE_WIN_MELODY_EN)
module beep_timer #(
  parameter int BEEP_CYCLES = 5_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear_i,
  input  logic load_i,
`ifdef SCORE_WIN_MELODY_EN
  input  logic melody_i,
`endif
  output logic busy_o
);

  localparam int CW = $clog2(BEEP_CYCLES + 1);
  localparam logic [CW-1:0] LOAD_VAL = CW'(BEEP_CYCLES);

  logic [CW-1:0] cnt_q, cnt_d;

`ifdef SCORE_WIN_MELODY_EN
  // Melody segment 1..5; odd segments sound, even segments are silent gaps.
  logic [2:0] seg_q, seg_d;

  // Next counter/segment: reload per segment until the fifth runs out.
  always_comb begin
    cnt_d = cnt_q;
    seg_d = seg_q;
    if (clear_i) begin
      cnt_d = '0;
      seg_d = 3'd0;
    end else if (melody_i) begin
      cnt_d = LOAD_VAL;
      seg_d = 3'd1;
    end else if (load_i) begin
      cnt_d = LOAD_VAL;
      seg_d = 3'd0;
    end else if (cnt_q != '0) begin
      if (cnt_q == CW'(1) && seg_q != 3'd0 && seg_q != 3'd5) begin
        cnt_d = LOAD_VAL;
        seg_d = seg_q + 3'd1;
      end else begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) seg_d = 3'd0;
      end
    end
  end

  // Counter and segment registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      seg_q <= 3'd0;
    end else begin
      cnt_q <= cnt_d;
      seg_q <= seg_d;
    end
  end

  assign busy_o = (seg_q != 3'd0) ? seg_q[0] : (cnt_q != '0);
`else
  // Next counter: reload on a point, otherwise count down to zero.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (load_i) begin
      cnt_d = LOAD_VAL;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign busy_o = (cnt_q != '0);
`endif

endmodule

// File: rtl/score_ctrl.sv
// rtl/score_ctrl.sv - Pong score arbiter, BCD scores and game-over FSM (SCORE_WIN_MELODY_EN)
module score_ctrl
  import score_pkg::*;
#(
  parameter int BEEP_CYCLES = 5_000_000,
  parameter int WIN_SCORE   = 9
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               p1_point,
  input  logic               p2_point,
  input  logic               new_game,
  output logic [SCORE_W-1:0] p1,
  output logic [SCORE_W-1:0] p2,
  output logic               beep,
  output logic               game_over,
  output logic               winner
);

  localparam logic [SCORE_W-1:0] WIN_VAL = SCORE_W'(WIN_SCORE);

  state_e             state_q, state_d;
  logic [SCORE_W-1:0] p1_q, p1_d, p2_q, p2_d;
  logic               pend1_q, pend1_d, pend2_q, pend2_d;
  logic               winner_q, winner_d;
  logic               beep_load, beep_win, beep_clear;

  // Arbitration (player 1 first), pending bookkeeping and game-over detection.
  always_comb begin
    state_d    = state_q;
    p1_d       = p1_q;
    p2_d       = p2_q;
    pend1_d    = pend1_q;
    pend2_d    = pend2_q;
    winner_d   = winner_q;
    beep_load  = 1'b0;
    beep_win   = 1'b0;
    beep_clear = 1'b0;
    if (new_game) begin
      state_d    = PLAY;
      p1_d       = '0;
      p2_d       = '0;
      pend1_d    = 1'b0;
      pend2_d    = 1'b0;
      winner_d   = P1;
      beep_clear = 1'b1;
    end else if (state_q == PLAY) begin
      if (p1_point || pend1_q) begin
        p1_d      = p1_q + SCORE_W'(1);
        pend1_d   = 1'b0;
        pend2_d   = pend2_q | p2_point;
        beep_load = 1'b1;
        if (p1_d == WIN_VAL) begin
          state_d  = OVER;
          winner_d = P1;
          pend1_d  = 1'b0;
          pend2_d  = 1'b0;
          beep_win = 1'b1;
        end
      end else if (p2_point || pend2_q) begin
        p2_d      = p2_q + SCORE_W'(1);
        pend2_d   = 1'b0;
        beep_load = 1'b1;
        if (p2_d == WIN_VAL) begin
          state_d  = OVER;
          winner_d = P2;
          pend1_d  = 1'b0;
          pend2_d  = 1'b0;
          beep_win = 1'b1;
        end
      end
    end
  end

  // Score, pending, winner and state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= PLAY;
      p1_q     <= '0;
      p2_q     <= '0;
      pend1_q  <= 1'b0;
      pend2_q  <= 1'b0;
      winner_q <= P1;
    end else begin
      state_q  <= state_d;
      p1_q     <= p1_d;
      p2_q     <= p2_d;
      pend1_q  <= pend1_d;
      pend2_q  <= pend2_d;
      winner_q <= winner_d;
    end
  end

`ifndef SCORE_WIN_MELODY_EN
  // The winning point beeps like any other point.
  logic unused_win;
  assign unused_win = beep_win;
`endif

  beep_timer #(
    .BEEP_CYCLES(BEEP_CYCLES)
  ) u_beep_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear_i (beep_clear),
    .load_i  (beep_load),
`ifdef SCORE_WIN_MELODY_EN
    .melody_i(beep_win),
`endif
    .busy_o  (beep)
  );

  assign p1        = p1_q;
  assign p2        = p2_q;
  assign game_over = (state_q == OVER);
  assign winner    = winner_q;

endmodule

// File: tb/tb_score_ctrl.sv
// tb/tb_score_ctrl.sv - randomized self-checking bench for score_ctrl against a queue-based model
module tb_score_ctrl;

`ifdef SCORE_WIN_MELODY_EN
  localparam int BC = 2;
`else
  localparam int BC = 4;
`endif
  localparam int WS = 9;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       p1_point = 1'b0;
  logic       p2_point = 1'b0;
  logic       new_game = 1'b0;
  logic [3:0] p1, p2;
  logic       beep, game_over, winner;

  int checks = 0;
  int failures = 0;

  score_ctrl #(.BEEP_CYCLES(BC), .WIN_SCORE(WS)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .p1_point (p1_point),
    .p2_point (p2_point),
    .new_game (new_game),
    .p1       (p1),
    .p2       (p2),
    .beep     (beep),
    .game_over(game_over),
    .winner   (winner)
  );

  always #5 clk = ~clk;

  // Reference: integer scores, pending flags, and the future beep waveform as a bit queue.
  int sc[2];
  bit pd[2];
  bit m_over;
  int m_win;
  bit bq[$];

  function automatic void m_reset();
    sc[0] = 0; sc[1] = 0; pd[0] = 0; pd[1] = 0;
    m_over = 0; m_win = 0;
    bq.delete();
  endfunction

  function automatic void m_step(bit a, bit b, bit ng);
    bit pulse[2];
    int g;
    pulse[0] = a;
    pulse[1] = b;
    if (bq.size() > 0) void'(bq.pop_front());
    if (ng) begin
      m_reset();
      return;
    end
    if (m_over) return;
    g = -1;
    for (int i = 0; i < 2; i++) if (g < 0 && (pulse[i] || pd[i])) g = i;
    for (int i = 0; i < 2; i++) if (i != g && pulse[i]) pd[i] = 1;
    if (g >= 0) begin
      pd[g] = 0;
      sc[g] = sc[g] + 1;
      bq.delete();
      for (int k = 0; k < BC; k++) bq.push_back(1'b1);
      if (sc[g] == WS) begin
        m_over = 1;
        m_win = g;
        pd[0] = 0;
        pd[1] = 0;
`ifdef SCORE_WIN_MELODY_EN
        bq.delete();
        for (int s = 0; s < 5; s++)
          for (int k = 0; k < BC; k++) bq.push_back((s % 2) == 0);
`endif
      end
    end
  endfunction

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic compare_all();
    check("p1", 32'(p1), sc[0]);
    check("p2", 32'(p2), sc[1]);
    check("beep", 32'(beep), (bq.size() > 0) ? 32'(bq[0]) : 0);
    check("game_over", 32'(game_over), 32'(m_over));
    if (m_over) check("winner", 32'(winner), m_win);
  endtask

  task automatic cycle(bit a, bit b, bit ng);
    p1_point = a;
    p2_point = b;
    new_game = ng;
    @(posedge clk);
    m_step(a, b, ng);
    @(negedge clk);
    p1_point = 0;
    p2_point = 0;
    new_game = 0;
    compare_all();
  endtask

  task automatic do_reset();
    #2 rst_n = 0;
    #1 m_reset();
    check("rst_async_p1", 32'(p1), 0);
    check("rst_async_p2", 32'(p2), 0);
    check("rst_async_beep", 32'(beep), 0);
    check("rst_async_go", 32'(game_over), 0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    compare_all();
  endtask

  initial begin
    @(negedge clk);
    do_reset();

    // Single uncontended point, beep length.
    repeat (9) cycle(0, 0, 0);
    cycle(1, 0, 0);
    check("tp1_p1", 32'(p1), 1);
    check("tp1_beep_start", 32'(beep), 1);
    repeat (BC - 1) cycle(0, 0, 0);
    check("tp1_beep_last", 32'(beep), 1);
    cycle(0, 0, 0);
    check("tp1_beep_end", 32'(beep), 0);

    // Simultaneous points are serialised.
    cycle(0, 0, 1);
    cycle(1, 1, 0);
    check("sim_p1", 32'(p1), 1);
    check("sim_p2_wait", 32'(p2), 0);
    cycle(0, 0, 0);
    check("sim_p2", 32'(p2), 1);
    repeat (BC + 2) cycle(0, 0, 0);

    // Win at 8/8 with a simultaneous pair: the pending player 2 point is lost.
    cycle(0, 0, 1);
    repeat (8) begin
      cycle(1, 0, 0);
      cycle(0, 1, 0);
    end
    cycle(1, 1, 0);
    check("win_p1", 32'(p1), 9);
    check("win_p2", 32'(p2), 8);
    check("win_go", 32'(game_over), 1);
    check("win_who", 32'(winner), 0);
    cycle(0, 1, 0);
    cycle(0, 0, 0);
    check("over_p2_frozen", 32'(p2), 8);
    repeat (5 * BC + 2) cycle(0, 1, 0);

    // new_game beats a simultaneous point.
    cycle(0, 1, 1);
    check("ng_p1", 32'(p1), 0);
    check("ng_p2", 32'(p2), 0);
    check("ng_go", 32'(game_over), 0);

    // Reset in the middle of a beep.
    repeat (3) cycle(0, 1, 0);
    check("pre_rst_p2", 32'(p2), 3);
    do_reset();
    repeat (BC + 2) cycle(0, 0, 0);

    // Randomized play with occasional new games and resets.
    for (int n = 0; n < 3000; n++) begin
      bit a, b, ng;
      a  = ($urandom % 6) == 0;
      b  = ($urandom % 6) == 0;
      ng = m_over ? (($urandom % 25) == 0) : (($urandom % 300) == 0);
      if (($urandom % 700) == 0) do_reset();
      else cycle(a, b, ng);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
